// File: rtl/serial_loop_adder_if.sv
// Operand/result bundle between the operand registers, the serial adder
// and the consuming stage.
interface serial_loop_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Upstream/consumer side: issues requests and observes the result.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side: accepts requests and publishes the result.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_loop_adder.sv
// Bit-serial adder: one NAND-level full-adder cell plus a registered carry
// loop processes one bit pair per cycle, LSB first. The result takes WIDTH
// RUN cycles, then is published for one DONE cycle and held afterwards.
module serial_loop_adder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_loop_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       fa_s;     // {carry_out, sum_bit} of the cell
    logic [WIDTH-1:0] psum_d;
    logic             last_s;

    // Full adder built only from two-input NANDs; returns {cout, sum}.
    function automatic logic [1:0] full_adder_nand(input logic x,
                                                   input logic y,
                                                   input logic ci);
        logic n1, n2, n3, xy, n4, n5, n6, s, co;
        n1 = ~(x & y);
        n2 = ~(x & n1);
        n3 = ~(y & n1);
        xy = ~(n2 & n3);
        n4 = ~(xy & ci);
        n5 = ~(xy & n4);
        n6 = ~(ci & n4);
        s  = ~(n5 & n6);
        co = ~(n4 & n1);
        return {co, s};
    endfunction

    // Cell evaluation and next partial sum (new bit enters at the MSB).
    always_comb begin
        fa_s              = full_adder_nand(opa_q[0], opb_q[0], carry_q);
        psum_d            = psum_q >> 1;
        psum_d[WIDTH-1]   = fa_s[0];
        last_s            = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM and datapath registers; busy/done registered with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        carry_q <= bus.cin;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    psum_q  <= psum_d;
                    carry_q <= fa_s[1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_s) begin
                        // Result is complete on this edge; publish it so it is
                        // visible during the DONE cycle.
                        sum_q   <= psum_d;
                        cout_q  <= fa_s[1];
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        carry_q <= bus.cin;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
